// File: rtl/layer4_ctrl_pkg.sv
// Shared types and helpers for the layer-4 result buffer controller.
//   l4c_state_t : frame lifecycle (IDLE -> FILL -> FULL -> IDLE)
//   L4_GRID     : grid side, L4_DEPTH : entries per frame
//   l4_index()  : raster index row*12+col built from shifts, 8 bits wide
package layer4_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } l4c_state_t;

  localparam int L4_GRID  = 12;
  localparam int L4_DEPTH = 144;

  // row*12 + col as (row<<4) - (row<<2) + col; callers range-check first,
  // so the 8-bit result cannot overflow for legal coordinates.
  function automatic logic [7:0] l4_index(input logic [7:0] row,
                                          input logic [7:0] col);
    logic [7:0] row_x16;
    logic [7:0] row_x4;
    row_x16 = row << 4;
    row_x4  = row << 2;
    return row_x16 - row_x4 + col;
  endfunction

endpackage

// File: rtl/layer4_raster_cnt.sv
// Raster (row, col) counter for the layer-4 result grid.
//   clk, rst : clock and synchronous active-high reset
//   clear    : synchronous return to (0,0)
//   enable   : advance one position; col wraps at WIDTH-1 and bumps row
//   row, col : current raster position
//   last     : current position is (WIDTH-1, WIDTH-1)
module layer4_raster_cnt #(
  parameter int WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        last
);

  localparam logic [15:0] LAST_POS = 16'(WIDTH - 1);

  logic [15:0] row_reg;
  logic [15:0] col_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (enable) begin
      if (col_reg == LAST_POS) begin
        col_reg <= '0;
        row_reg <= (row_reg == LAST_POS) ? '0 : row_reg + 16'd1;
      end else begin
        col_reg <= col_reg + 16'd1;
      end
    end
  end

  assign row  = row_reg;
  assign col  = col_reg;
  assign last = (row_reg == LAST_POS) && (col_reg == LAST_POS);

endmodule

// File: rtl/layer4_result_mem_ctrl.sv
// Sequencing controller for the layer-4 result buffer (WIDTH x WIDTH
// entries of DATA_W bits in dual-port SRAM).
//   start / frame_release        : frame lifecycle controls
//   in_valid / in_ready / in_data: raster-order producer handshake
//   save_*, layer4_result_store_data_in : registered buffer write port
//   rd_req / rd_row / rd_col     : consumer read request (held until rd_gnt)
//   rd_gnt / rd_err              : combinational grant, one-shot range error
//   read_*_addr, layer4_result_read_signal, rd_data_valid : buffer read port
//   wr_count / frame_full        : committed entries and FULL indication
module layer4_result_mem_ctrl
  import layer4_ctrl_pkg::*;
#(
  parameter int WIDTH  = L4_GRID,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              save_enable,
  output logic [15:0]       save_row_addr,
  output logic [15:0]       save_col_addr,
  output logic [DATA_W-1:0] layer4_result_store_data_in,
  input  logic              rd_req,
  input  logic [15:0]       rd_row,
  input  logic [15:0]       rd_col,
  output logic              rd_gnt,
  output logic              rd_err,
  output logic [15:0]       read_row_addr,
  output logic [15:0]       read_col_addr,
  output logic              layer4_result_read_signal,
  output logic              rd_data_valid,
  output logic [7:0]        wr_count,
  output logic              frame_full,
  input  logic              frame_release
);

  localparam logic [7:0]  DEPTH = 8'(WIDTH * WIDTH);
  localparam logic [15:0] GRID  = 16'(WIDTH);

  l4c_state_t state_reg, state_next;

  logic              save_enable_reg;
  logic [15:0]       save_row_reg;
  logic [15:0]       save_col_reg;
  logic [DATA_W-1:0] save_data_reg;
  logic [7:0]        wr_count_reg;
  logic              rd_data_valid_reg;
  logic              err_hold_reg;
  logic              raster_done_reg;

  logic [15:0] raster_row;
  logic [15:0] raster_col;
  logic        raster_last;
  logic        accept;
  logic        wr_done;
  logic [8:0]  occupancy;
  logic        rd_in_range;
  logic        rd_bad;
  logic [7:0]  rd_idx;

  // ---------------- write side ----------------
  // Occupancy counts the registered-but-not-yet-written entry so the
  // producer is throttled exactly at DEPTH, not one entry late.
  assign occupancy = {1'b0, wr_count_reg} + {8'd0, save_enable_reg};
  assign in_ready  = (state_reg == FILL) && (occupancy < {1'b0, DEPTH})
                     && !raster_done_reg;
  assign accept    = in_valid && in_ready;

  layer4_raster_cnt #(.WIDTH(WIDTH)) u_raster (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_reg == IDLE),
    .enable (accept),
    .row    (raster_row),
    .col    (raster_col),
    .last   (raster_last)
  );

  assign wr_done = save_enable_reg && (wr_count_reg == DEPTH - 8'd1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)         state_next = FILL;
      FILL:    if (wr_done)       state_next = FULL;
      FULL:    if (frame_release) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      save_enable_reg   <= 1'b0;
      save_row_reg      <= '0;
      save_col_reg      <= '0;
      save_data_reg     <= '0;
      wr_count_reg      <= '0;
      rd_data_valid_reg <= 1'b0;
      err_hold_reg      <= 1'b0;
      raster_done_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      save_enable_reg <= accept;
      if (accept) begin
        save_row_reg  <= raster_row;
        save_col_reg  <= raster_col;
        save_data_reg <= in_data;
      end
      // Leaving FULL clears the count so IDLE is entered with zero.
      if ((state_reg == FULL) && frame_release)
        wr_count_reg <= '0;
      else if (save_enable_reg)
        wr_count_reg <= wr_count_reg + 8'd1;
      // Sticky guard: once (last,last) is taken nothing more is accepted.
      if (state_reg == IDLE)
        raster_done_reg <= 1'b0;
      else if (accept && raster_last)
        raster_done_reg <= 1'b1;
      rd_data_valid_reg <= rd_gnt;
      err_hold_reg      <= rd_bad;
    end
  end

  assign save_enable                 = save_enable_reg;
  assign save_row_addr               = save_row_reg;
  assign save_col_addr               = save_col_reg;
  assign layer4_result_store_data_in = save_data_reg;
  assign wr_count                    = wr_count_reg;
  assign frame_full                  = (state_reg == FULL);

  // ---------------- read side ----------------
  // Range check uses the full 16 bits; the index only needs the low byte
  // once both coordinates are known to be below WIDTH.
  assign rd_in_range = (rd_row < GRID) && (rd_col < GRID);
  assign rd_idx      = l4_index(rd_row[7:0], rd_col[7:0]);
  assign rd_gnt      = rd_req && rd_in_range && (rd_idx < wr_count_reg)
                       && (state_reg != IDLE);
  assign rd_bad      = rd_req && !rd_in_range;
  // A held bad request reports once, on its first cycle.
  assign rd_err      = rd_bad && !err_hold_reg;

  // Address outputs are forced to zero whenever no grant is issued.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rd_addr
      assign read_row_addr[gi] = rd_row[gi] & rd_gnt;
      assign read_col_addr[gi] = rd_col[gi] & rd_gnt;
    end
  endgenerate

  assign rd_data_valid             = rd_data_valid_reg;
  assign layer4_result_read_signal = rd_gnt || rd_data_valid_reg;

endmodule

// File: tb/tb_layer4_result_mem_ctrl.sv
module tb_layer4_result_mem_ctrl;
  localparam int W  = 12;
  localparam int D  = 144;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          rd_req = 1'b0;
  logic [15:0]   rd_row = '0;
  logic [15:0]   rd_col = '0;
  logic          frame_release = 1'b0;

  logic          in_ready, save_enable, rd_gnt, rd_err;
  logic          layer4_result_read_signal, rd_data_valid, frame_full;
  logic [15:0]   save_row_addr, save_col_addr, read_row_addr, read_col_addr;
  logic [DW-1:0] layer4_result_store_data_in;
  logic [7:0]    wr_count;

  layer4_result_mem_ctrl #(.WIDTH(W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .save_enable(save_enable), .save_row_addr(save_row_addr),
    .save_col_addr(save_col_addr),
    .layer4_result_store_data_in(layer4_result_store_data_in),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_gnt(rd_gnt), .rd_err(rd_err),
    .read_row_addr(read_row_addr), .read_col_addr(read_col_addr),
    .layer4_result_read_signal(layer4_result_read_signal),
    .rd_data_valid(rd_data_valid), .wr_count(wr_count),
    .frame_full(frame_full), .frame_release(frame_release)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- behavioural model ----------------
  // state: 0 idle, 1 filling, 2 full. m_acc = results accepted this frame,
  // m_wr = results committed; the write of result k lands at (k/12, k%12).
  int            m_state = 0;
  int            m_wr = 0;
  int            m_acc = 0;
  bit            m_save_en = 0;
  int            m_save_idx = 0;
  logic [DW-1:0] m_save_data = '0;
  bit            m_dv = 0;
  bit            m_prev_bad = 0;
  bit            last_gnt = 0;
  int            last_gnt_wr = 0;
  bit            check_en = 0;

  function automatic bit f_in_range();
    return (rd_row < 16'd12) && (rd_col < 16'd12);
  endfunction
  function automatic bit f_gnt();
    int idx;
    idx = int'(rd_row) * 12 + int'(rd_col);
    return rd_req && f_in_range() && (idx < m_wr) && (m_state != 0);
  endfunction
  function automatic bit f_ready();
    return (m_state == 1) && (m_acc < D);
  endfunction
  function automatic bit f_err();
    return rd_req && !f_in_range() && !m_prev_bad;
  endfunction

  bit u_g, u_acc, u_bad;
  int u_wr;
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_wr = 0; m_acc = 0; m_save_en = 0; m_save_idx = 0;
      m_save_data = '0; m_dv = 0; m_prev_bad = 0; last_gnt = 0;
    end else begin
      u_g   = f_gnt();
      u_acc = in_valid && f_ready();
      u_bad = rd_req && !f_in_range();
      u_wr  = m_wr + (m_save_en ? 1 : 0);
      last_gnt = u_g;
      if (u_g) last_gnt_wr = m_wr;
      m_save_en = u_acc;
      if (u_acc) begin
        m_save_idx  = m_acc;
        m_save_data = in_data;
        m_acc++;
      end
      case (m_state)
        0: if (start) m_state = 1;
        1: if (u_wr == D) m_state = 2;
        default: if (frame_release) begin
          m_state = 0; u_wr = 0; m_acc = 0;
        end
      endcase
      m_wr       = u_wr;
      m_dv       = u_g;
      m_prev_bad = u_bad;
    end
  end

  // ---------------- compare process ----------------
  int run_len = 0;
  int max_run = 0;
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("in_ready", in_ready, f_ready());
      chk("save_enable", save_enable, m_save_en);
      if (m_save_en) begin
        chk("save_row", save_row_addr, m_save_idx / 12);
        chk("save_col", save_col_addr, m_save_idx % 12);
        chk("save_data", layer4_result_store_data_in, m_save_data);
      end
      chk("rd_gnt", rd_gnt, f_gnt());
      chk("rd_err", rd_err, f_err());
      chk("read_row", read_row_addr, f_gnt() ? rd_row : 16'd0);
      chk("read_col", read_col_addr, f_gnt() ? rd_col : 16'd0);
      chk("rd_data_valid", rd_data_valid, m_dv);
      chk("read_signal", layer4_result_read_signal, f_gnt() || m_dv);
      chk("wr_count", wr_count, m_wr);
      chk("frame_full", frame_full, m_state == 2);
      if (save_enable) run_len++;
      else begin
        if (run_len > max_run) max_run = run_len;
        run_len = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    in_data = rnd128();
  endtask

  // ---------------- stimulus ----------------
  bit good_req = 0;
  int bad_left = 0;
  initial begin
    int n;
    @(posedge clk);
    #1 check_en = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_save_en", save_enable, 0);
    chk("rst_gnt", rd_gnt, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_read_sig", layer4_result_read_signal, 0);
    chk("rst_dv", rd_data_valid, 0);
    chk("rst_full", frame_full, 0);
    chk("rst_save_row", save_row_addr, 0);
    chk("rst_save_col", save_col_addr, 0);
    chk("rst_save_data", layer4_result_store_data_in, 0);
    chk("rst_wr_count", wr_count, 0);
    rst = 0;

    // Phase A: back-to-back fill with directed reads.
    step(); start = 1; in_valid = 1;
    step(); start = 0;
    max_run = 0; run_len = 0;
    n = 0;
    while (!save_enable && n < 10) begin step(); n++; end
    chk("first_save_seen", save_enable, 1);
    step(); rd_req = 1; rd_row = 0; rd_col = 0;
    #1 chk("gnt_0_0", rd_gnt, 1);
    step(); rd_req = 0; start = 1;
    #1 chk("dv_0_0", rd_data_valid, 1);
    chk("read_sig_held", layer4_result_read_signal, 1);
    step(); start = 0;
    n = 0;
    while (wr_count != 8'd20 && n < 200) begin step(); n++; end
    chk("reach_wr20", wr_count, 20);
    rd_req = 1; rd_row = 2; rd_col = 5;
    n = 0;
    do begin step(); n++; end while (!last_gnt && n < 100);
    rd_req = 0;
    chk("gnt_2_5_seen", last_gnt, 1);
    chk("gnt_2_5_at_wr", last_gnt_wr, 30);
    rd_req = 1; rd_row = 12; rd_col = 0;
    #1 chk("err_12_0", rd_err, 1);
    chk("err_12_0_nognt", rd_gnt, 0);
    step();
    #1 chk("err_held_once", rd_err, 0);
    step(); rd_req = 0;
    n = 0;
    while (!frame_full && n < 300) begin step(); n++; end
    in_valid = 0;
    chk("full_reached", frame_full, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_wr_count", wr_count, 144);
    step();
    #3 chk("save_run_len", max_run, 144);

    // Phase B: release, refill, reset mid-frame with a write pending.
    frame_release = 1;
    step(); frame_release = 0;
    #1 chk("rel_wr_count", wr_count, 0);
    chk("rel_full", frame_full, 0);
    start = 1; in_valid = 1;
    step(); start = 0;
    n = 0;
    while (!(m_acc == 50 && m_save_en) && n < 100) begin step(); n++; end
    chk("acc50_pending", save_enable, 1);
    rst = 1;
    step(); in_valid = 0;
    #1 chk("mid_rst_save_en", save_enable, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_wr_count", wr_count, 0);
    chk("mid_rst_save_row", save_row_addr, 0);
    chk("mid_rst_full", frame_full, 0);
    step(); rst = 0;

    // Phase C: randomized traffic.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      rst           = ($urandom_range(0, 599) == 0);
      start         = ($urandom_range(0, 7) == 0);
      frame_release = ($urandom_range(0, 5) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      if (rd_req && good_req && last_gnt) rd_req = 0;
      if (rd_req && !good_req) begin
        bad_left--;
        if (bad_left <= 0) rd_req = 0;
      end
      if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_req = 1;
        if ($urandom_range(0, 7) == 0) begin
          good_req = 0;
          bad_left = $urandom_range(1, 3);
          if ($urandom_range(0, 1) == 0) begin
            rd_row = 16'($urandom_range(12, 65535)); rd_col = 16'($urandom_range(0, 11));
          end else begin
            rd_row = 16'($urandom_range(0, 11)); rd_col = 16'($urandom_range(12, 300));
          end
        end else begin
          good_req = 1;
          rd_row = 16'($urandom_range(0, 11));
          rd_col = 16'($urandom_range(0, 11));
        end
      end
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
